// File: rtl/aes_128_pkg.sv
// Shared constants and state encoding for the AES-128 inverse-cipher control logic.
package aes_128_pkg;

    parameter int unsigned NR            = 10;
    parameter int unsigned CLK_PER_ROUND = 3;

    typedef enum logic [1:0] {
        StIdle,
        StKeyExp,
        StReady,
        StDec
    } state_t;

endpackage

// File: rtl/aes_128_inv_control_3clk.sv
// Sequencer for an AES-128 decryptor with iterative key expansion and a multi-clock round:
// drives round-key store write/read strobes, InvMixColumns bypass and block handshakes.
module aes_128_inv_control_3clk
    import aes_128_pkg::*;
#(
    parameter int unsigned NR            = aes_128_pkg::NR,
    parameter int unsigned CLK_PER_ROUND = aes_128_pkg::CLK_PER_ROUND
) (
    input  logic       clk,
    input  logic       kill,
    input  logic       key_en,
    input  logic       in_en,
    output logic       start,
    output logic       rk_wr_en,
    output logic [3:0] rk_wr_addr,
    output logic       rk_rd_en,
    output logic [3:0] rk_rd_addr,
    output logic       key_valid,
    output logic       en_invmixcol,
    output logic       busy,
    output logic       out_en,
    output logic       collision_irq_pulse
);

    localparam logic [3:0] LastKey    = 4'(NR);
    localparam logic [4:0] LastCount  = 5'(NR * CLK_PER_ROUND - 1);
    localparam logic [4:0] PreFinal   = 5'((NR - 1) * CLK_PER_ROUND - 1);
    localparam logic [1:0] PhaseLast  = 2'(CLK_PER_ROUND - 1);
    localparam logic [1:0] PhaseFetch = 2'(CLK_PER_ROUND - 2);

    state_t     state;
    state_t     state_next;
    logic       key_accept;
    logic       reject;
    logic [4:0] round_count;
    logic [1:0] phase;
    logic [3:0] round;
    logic       rd_pulse;
    logic [3:0] rd_addr_hold;

    assign key_accept = key_en & ~kill & ((state == StIdle) | (state == StReady));
    assign start      = in_en & ~kill & ~key_en & (state == StReady);
    assign reject     = ~kill & ((in_en & ~start) | (key_en & busy));

    always_ff @(posedge clk) begin
        if (kill) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle: begin
                if (key_accept) state_next = StKeyExp;
            end
            StKeyExp: begin
                if (rk_wr_addr == LastKey) state_next = StReady;
            end
            StReady: begin
                if (key_accept) begin
                    state_next = StKeyExp;
                end else if (start) begin
                    state_next = StDec;
                end
            end
            StDec: begin
                if (round_count == LastCount) state_next = StReady;
            end
            default: state_next = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state == StKeyExp) | (state == StDec);
        rk_rd_en   = start | rd_pulse;
        // The initial AddRoundKey fetch is issued in the acceptance cycle itself.
        rk_rd_addr = start ? LastKey : rd_addr_hold;
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            round_count         <= '0;
            phase               <= '0;
            round               <= '0;
            key_valid           <= 1'b0;
            rk_wr_en            <= 1'b0;
            rk_wr_addr          <= '0;
            rd_pulse            <= 1'b0;
            rd_addr_hold        <= '0;
            en_invmixcol        <= 1'b1;
            out_en              <= 1'b0;
            collision_irq_pulse <= 1'b0;
        end else begin
            rd_pulse            <= 1'b0;
            out_en              <= 1'b0;
            collision_irq_pulse <= reject;

            if (key_accept) begin
                rk_wr_en   <= 1'b1;
                rk_wr_addr <= '0;
                key_valid  <= 1'b0;
            end else if (state == StKeyExp) begin
                if (rk_wr_addr == LastKey) begin
                    rk_wr_en  <= 1'b0;
                    key_valid <= 1'b1;
                end else begin
                    rk_wr_addr <= rk_wr_addr + 4'd1;
                end
            end

            if (start) begin
                round_count  <= '0;
                phase        <= '0;
                round        <= 4'd1;
                rd_addr_hold <= LastKey;
            end else if (state == StDec) begin
                if (round_count == LastCount) begin
                    round_count  <= '0;
                    en_invmixcol <= 1'b1;
                    out_en       <= 1'b1;
                end else begin
                    round_count <= round_count + 5'd1;
                end
                // Final round skips InvMixColumns.
                if (round_count == PreFinal) en_invmixcol <= 1'b0;
                if (phase == PhaseFetch) begin
                    rd_pulse     <= 1'b1;
                    rd_addr_hold <= LastKey - round;
                end
                if (phase == PhaseLast) begin
                    phase <= '0;
                    round <= round + 4'd1;
                end else begin
                    phase <= phase + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_128_inv_control_3clk.sv
// Self-checking bench: directed scenario plus random traffic against an elapsed-time model.
module tb_aes_128_inv_control_3clk;

    localparam int MIdle  = 0;
    localparam int MKey   = 1;
    localparam int MReady = 2;
    localparam int MDec   = 3;

    logic       clk = 1'b1;
    logic       kill;
    logic       key_en;
    logic       in_en;
    logic       start;
    logic       rk_wr_en;
    logic [3:0] rk_wr_addr;
    logic       rk_rd_en;
    logic [3:0] rk_rd_addr;
    logic       key_valid;
    logic       en_invmixcol;
    logic       busy;
    logic       out_en;
    logic       collision_irq_pulse;

    aes_128_inv_control_3clk dut (
        .clk                 (clk),
        .kill                (kill),
        .key_en              (key_en),
        .in_en               (in_en),
        .start               (start),
        .rk_wr_en            (rk_wr_en),
        .rk_wr_addr          (rk_wr_addr),
        .rk_rd_en            (rk_rd_en),
        .rk_rd_addr          (rk_rd_addr),
        .key_valid           (key_valid),
        .en_invmixcol        (en_invmixcol),
        .busy                (busy),
        .out_en              (out_en),
        .collision_irq_pulse (collision_irq_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: mode plus cycle of the accepted request; outputs follow from elapsed time.
    bit known = 0;
    int mode  = MIdle;
    int t0    = 0;
    bit m_kv, m_out, m_coll;
    int m_wr, m_rd;
    int out_count = 0;
    int e, e_wr, e_rd;
    bit e_start, e_rdp, e_wren;

    always @(negedge clk) begin
        e       = cyc - t0;
        e_start = in_en && mode == MReady && !key_en && !kill;
        e_rdp   = (mode == MDec) && (e % 3 == 0);
        e_wren  = (mode == MKey);
        e_wr    = e_wren ? e - 1 : m_wr;
        e_rd    = e_start ? 10 : (e_rdp ? 10 - e / 3 : m_rd);
        if (known) begin
            chk("start", start, e_start);
            chk("busy", busy, (mode == MKey || mode == MDec));
            chk("key_valid", key_valid, m_kv);
            chk("rk_wr_en", rk_wr_en, e_wren);
            chk("rk_wr_addr", rk_wr_addr, e_wr);
            chk("rk_rd_en", rk_rd_en, e_start || e_rdp);
            chk("rk_rd_addr", rk_rd_addr, e_rd);
            chk("en_invmixcol", en_invmixcol, !(mode == MDec && e >= 28));
            chk("out_en", out_en, m_out);
            chk("collision", collision_irq_pulse, m_coll);
            if (out_en === 1'b1) out_count++;
        end
        if (kill) begin
            known  = 1;
            mode   = MIdle;
            m_kv   = 0;
            m_wr   = 0;
            m_rd   = 0;
            m_out  = 0;
            m_coll = 0;
        end else if (known) begin
            m_coll = (in_en && !e_start) || (key_en && (mode == MKey || mode == MDec));
            m_out  = 0;
            m_wr   = e_wr;
            m_rd   = e_rd;
            case (mode)
                MIdle, MReady: begin
                    if (key_en) begin
                        mode = MKey;
                        t0   = cyc;
                        m_kv = 0;
                    end else if (e_start) begin
                        mode = MDec;
                        t0   = cyc;
                    end
                end
                MKey: if (e == 11) begin
                    mode = MReady;
                    m_kv = 1;
                end
                default: if (e == 30) begin
                    mode  = MReady;
                    m_out = 1;
                end
            endcase
        end
        cyc++;
    end

    initial begin
        kill   = 1'b0;
        key_en = 1'b0;
        in_en  = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c < 140) begin
                kill   = (c == 0) || (c == 115);
                key_en = (c == 5) || (c == 83);
                in_en  = (c == 3) || (c == 20) || (c == 30) || (c == 51) || (c == 83)
                         || (c == 100);
            end else begin
                kill   = ($urandom_range(199) == 0);
                key_en = ($urandom_range(39) == 0);
                in_en  = ($urandom_range(5) == 0);
            end
            #1;
            case (c)
                3:   chk("pin_start_idle", start, 0);
                4:   chk("pin_coll_idle", collision_irq_pulse, 1);
                5:   chk("pin_kv_after_kill", key_valid, 0);
                6:   begin
                    chk("pin_wr_first_en", rk_wr_en, 1);
                    chk("pin_wr_first_addr", rk_wr_addr, 0);
                end
                16:  chk("pin_wr_last_addr", rk_wr_addr, 10);
                17:  begin
                    chk("pin_kv_ready", key_valid, 1);
                    chk("pin_wr_done", rk_wr_en, 0);
                end
                20:  begin
                    chk("pin_start_accept", start, 1);
                    chk("pin_rd_initial", rk_rd_addr, 10);
                end
                21:  chk("pin_rd_idle", rk_rd_en, 0);
                23:  begin
                    chk("pin_rd_r1_en", rk_rd_en, 1);
                    chk("pin_rd_r1_addr", rk_rd_addr, 9);
                end
                30:  chk("pin_start_dec", start, 0);
                31:  chk("pin_coll_dec", collision_irq_pulse, 1);
                47:  chk("pin_imc_r9", en_invmixcol, 1);
                48:  chk("pin_imc_r10", en_invmixcol, 0);
                50:  chk("pin_rd_r10_addr", rk_rd_addr, 0);
                51:  begin
                    chk("pin_out_first", out_en, 1);
                    chk("pin_start_b2b", start, 1);
                end
                52:  chk("pin_out_pulse", out_en, 0);
                82:  chk("pin_out_second", out_en, 1);
                83:  chk("pin_key_wins", start, 0);
                84:  begin
                    chk("pin_coll_key_wins", collision_irq_pulse, 1);
                    chk("pin_keyexp_again", rk_wr_en, 1);
                end
                116: begin
                    chk("pin_kill_busy", busy, 0);
                    chk("pin_kill_kv", key_valid, 0);
                end
                131: chk("pin_no_out_killed", out_en, 0);
                139: chk("pin_out_count", out_count, 2);
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
